// File: rtl/alu_share_pkg.sv
// Shared constants and types for the ALU share arbiter.
// Control codes are the select inputs of the ALU's per-bit 8:1 op muxes.
package alu_share_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic {
    IDLE,
    EXEC
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns the winner as both a one-hot vector and an index.
module rr_picker
  import alu_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int w_j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    w_j          = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(ptr) + k) % NREQ;
      if (!any && req[w_j]) begin
        any               = 1'b1;
        grant_idx         = IW'(w_j);
        grant_onehot[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external ALU between NREQ requesters.
// Optional flag return path: define ALU_SHARE_FLAGS_EN.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_cntrl,
  input  logic [WIDTH-1:0]  alu_result,
`ifdef ALU_SHARE_FLAGS_EN
  input  logic [3:0]        alu_flags,
  output logic [3:0]        rsp_flags,
`endif
  output logic [NREQ-1:0]   rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_t        r_state;
  arb_state_t        w_nstate;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_g;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_cntrl;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_any;
  logic              w_take;
  logic              w_busy;

  rr_picker #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req         (req_valid),
    .ptr         (r_ptr),
    .grant_onehot(w_gnt_oh),
    .grant_idx   (w_gnt_idx),
    .any         (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE: if (w_any) w_nstate = EXEC;
      EXEC: w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    w_take    = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_gnt_oh;
        w_take    = w_any;
      end
      EXEC: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // The EXEC cycle sees the ALU output for the registered operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_g         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cntrl     <= 3'b000;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_take) begin
        r_a     <= req_a[w_gnt_idx*WIDTH +: WIDTH];
        r_b     <= req_b[w_gnt_idx*WIDTH +: WIDTH];
        r_cntrl <= req_op[w_gnt_idx*3 +: 3];
        r_g     <= w_gnt_idx;
      end
      if (w_busy) begin
        r_rsp_data  <= alu_result;
        r_rsp_valid <= NREQ'(1) << r_g;
        r_ptr       <= (r_g == IW'(NREQ-1)) ? '0 : r_g + 1'b1;
      end
    end
  end

`ifdef ALU_SHARE_FLAGS_EN
  logic [3:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset)       r_flags <= 4'b0000;
    else if (w_busy) r_flags <= alu_flags;
  end

  assign rsp_flags = r_flags;
`endif

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_cntrl = r_cntrl;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = w_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter with a bench-side ALU.
// Flag path is exercised when ALU_SHARE_FLAGS_EN is defined.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  typedef struct {
    int         idx;
    logic [W-1:0] d;
    logic [3:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2:0]     alu_cntrl;
  logic [W-1:0]   alu_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [3:0]     alu_flags;
  logic [3:0]     rsp_flags;

  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic [2:0]   op[N];

  int checks   = 0;
  int failures = 0;

  exp_t q[$];
  logic         m_busy;
  int           m_ptr;
  int           m_g;
  logic [W-1:0] m_ea;
  logic [W-1:0] m_eb;
  logic [2:0]   m_eop;
  logic [W-1:0] m_last;
  logic         chk_rst;
  logic         mon_on = 1'b0;
  int           last_gnt;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
    case (o)
      ALU_PASS_B: return y;
      ALU_ADD:    return x + y;
      ALU_SUB:    return x - y;
      ALU_AND:    return x & y;
      ALU_OR:     return x | y;
      ALU_XOR:    return x ^ y;
      default:    return ~x ^ y;
    endcase
  endfunction

  function automatic logic [3:0] flag_f(input logic [W-1:0] r);
    return {r[W-1], r == '0, 2'b00};
  endfunction

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
      req_op[i*3 +: 3] = op[i];
    end
  end

  assign alu_result = alu_f(alu_a, alu_b, alu_cntrl);
  assign alu_flags  = flag_f(alu_result);

  alu_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cntrl (alu_cntrl),
    .alu_result(alu_result),
`ifdef ALU_SHARE_FLAGS_EN
    .alu_flags (alu_flags),
    .rsp_flags (rsp_flags),
`endif
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

`ifndef ALU_SHARE_FLAGS_EN
  assign rsp_flags = 4'b0000;
`endif

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs already applied at the negedge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    #1;
    last_gnt = -1;
    if (reset) begin
      q.delete();
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_last  = '0;
      chk_rst = 1'b1;
    end else begin
      if (chk_rst) begin
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_cntrl", W'(alu_cntrl), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_flags", W'(rsp_flags), '0);
        chk_rst = 1'b0;
      end
      if (!m_busy) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", W'(req_ready), W'(er));
        chk("busy_idle", W'(busy), '0);
        if (g >= 0) begin
          m_busy = 1'b1;
          m_g    = g;
          m_ea   = a[g];
          m_eb   = b[g];
          m_eop  = op[g];
          last_gnt = g;
          q.push_back('{g, alu_f(a[g], b[g], op[g]),
                        flag_f(alu_f(a[g], b[g], op[g]))});
        end
      end else begin
        chk("ready_exec", W'(req_ready), '0);
        chk("busy_exec", W'(busy), W'(1));
        chk("alu_a", alu_a, m_ea);
        chk("alu_b", alu_b, m_eb);
        chk("alu_cntrl", W'(alu_cntrl), W'(m_eop));
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic reroll(input int i);
    req_valid[i] = ($urandom % 2) == 0;
    if ($urandom % 4 == 0) begin
      a[i] = W'($urandom % 16);
      b[i] = W'($urandom % 16);
    end else begin
      a[i] = {$urandom, $urandom};
      b[i] = {$urandom, $urandom};
    end
    op[i] = 3'($urandom % 8);
  endtask

  initial begin
    exp_t e;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", W'(rsp_valid), '0);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", W'(rsp_valid), W'(1) << e.idx);
          chk("rsp_data", rsp_data, e.d);
`ifdef ALU_SHARE_FLAGS_EN
          chk("rsp_flags", W'(rsp_flags), W'(e.f));
`endif
          m_last = e.d;
        end
      end else begin
        chk("rsp_hold", rsp_data, m_last);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a[i]  = '0;
      b[i]  = '0;
      op[i] = 3'b000;
    end
    m_busy  = 1'b0;
    m_ptr   = 0;
    m_last  = '0;
    chk_rst = 1'b0;
    @(negedge clk);
    step();
    step();
    mon_on = 1'b1;
    reset  = 1'b0;
    repeat (5) step();

    a[2] = 64'd5; b[2] = 64'd3; op[2] = ALU_ADD;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (3) step();

    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      a[i] = W'(i + 10); b[i] = 64'd1; op[i] = ALU_SUB;
    end
    req_valid = 4'b1111;
    step();
    reset = 1'b0;
    repeat (10) step();
    req_valid = '0;
    repeat (3) step();

    a[1] = 64'd1; b[1] = 64'd1; op[1] = ALU_SUB;
    a[3] = 64'd7; b[3] = 64'd2; op[3] = ALU_XOR;
    req_valid = 4'b1010;
    repeat (6) step();
    req_valid = '0;
    repeat (3) step();

    a[0] = 64'd9; b[0] = 64'd4; op[0] = ALU_OR;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (3) step();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt == i) reroll(i);
        else if (!req_valid[i] && $urandom % 3 == 0) reroll(i);
        else if (req_valid[i] && $urandom % 16 == 0) reroll(i);
      end
      reset = ($urandom % 250) == 0;
      step();
    end
    reset = 1'b0;
    req_valid = '0;
    repeat (4) step();
    chk("queue_drained", W'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
